// File: rtl/pwm_pkg.sv
// Shared constants, state encoding and dead-time range for the
// half-bridge PWM switch controller.
package pwm_pkg;

   localparam int CNT_W = 10;
   localparam logic [CNT_W-1:0] CNT_MAX = 10'h3FF;

   localparam int TM_W   = 6;
   localparam int TM_MIN = 1;
   localparam int TM_MAX = 63;

   typedef enum logic [2:0] {
      REPOSO,
      MUERTO_A_ALTA,
      ALTA,
      MUERTO_A_BAJA,
      BAJA
   } estado_t;

   // Out-of-range dead times saturate to the nearest legal value.
   function automatic logic [TM_W-1:0] tm_ajustado(input int t);
      if (t < TM_MIN) return TM_W'(TM_MIN);
      if (t > TM_MAX) return TM_W'(TM_MAX);
      return TM_W'(t);
   endfunction

endpackage

// File: rtl/temporizador_muerto.sv
// Dead-time down-counter: loads on Carga, flags the last cycle of
// the dead interval on Expira.
module temporizador_muerto
   import pwm_pkg::*;
(
   input  logic            Clk,
   input  logic            Reset,
   input  logic            Carga,
   input  logic [TM_W-1:0] Valor,
   output logic            Expira
);

   localparam logic [TM_W-1:0] UNO = TM_W'(1);

   logic [TM_W-1:0] cuenta;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         cuenta <= '0;
      end else if (Carga) begin
         cuenta <= Valor;
      end else if (cuenta != '0) begin
         cuenta <= cuenta - UNO;
      end
   end

   // Loaded with N, the count reaches 1 on the Nth dead cycle.
   assign Expira = (cuenta == UNO);

endmodule

// File: rtl/conmutador_pwm.sv
// Half-bridge PWM switch: period-shadowed duty, registered compare and
// a dead-time FSM driving complementary high/low switch commands.
module conmutador_pwm
   import pwm_pkg::*;
#(
   parameter int TIEMPO_MUERTO = 8
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Enable,
   input  logic [CNT_W-1:0] Conteo,
   input  logic [CNT_W-1:0] Ciclo_Trabajo,
   output logic             Salida_Alta,
   output logic             Salida_Baja,
   output logic             Fin_Periodo
);

   localparam logic [TM_W-1:0] TM = tm_ajustado(TIEMPO_MUERTO);

   logic [CNT_W-1:0] duty_act;
   logic             pwm_raw;
   logic             carga;
   logic             expira;
   estado_t          estado;

   wire fin = Enable && (Conteo == CNT_MAX);

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         duty_act    <= '0;
         pwm_raw     <= 1'b0;
         Fin_Periodo <= 1'b0;
      end else begin
         Fin_Periodo <= fin;
         pwm_raw     <= Enable && (Conteo < duty_act);
         if (fin) duty_act <= Ciclo_Trabajo;
      end
   end

   // Timer reloads on every edge that enters a dead-time state.
   always_comb begin
      carga = 1'b0;
      if (Enable) begin
         unique case (estado)
            REPOSO:  carga = 1'b1;
            ALTA:    carga = !pwm_raw;
            BAJA:    carga = pwm_raw;
            default: carga = 1'b0;
         endcase
      end
   end

   temporizador_muerto u_tm (
      .Clk    (Clk),
      .Reset  (Reset),
      .Carga  (carga),
      .Valor  (TM),
      .Expira (expira)
   );

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         estado      <= REPOSO;
         Salida_Alta <= 1'b0;
         Salida_Baja <= 1'b0;
      end else if (!Enable) begin
         estado      <= REPOSO;
         Salida_Alta <= 1'b0;
         Salida_Baja <= 1'b0;
      end else begin
         unique case (estado)
            REPOSO: begin
               estado      <= pwm_raw ? MUERTO_A_ALTA : MUERTO_A_BAJA;
               Salida_Alta <= 1'b0;
               Salida_Baja <= 1'b0;
            end
            MUERTO_A_ALTA, MUERTO_A_BAJA: begin
               // Final side follows pwm_raw at expiry, not the entry target.
               if (expira) begin
                  estado      <= pwm_raw ? ALTA : BAJA;
                  Salida_Alta <= pwm_raw;
                  Salida_Baja <= !pwm_raw;
               end
            end
            ALTA: begin
               if (!pwm_raw) begin
                  estado      <= MUERTO_A_BAJA;
                  Salida_Alta <= 1'b0;
               end
            end
            BAJA: begin
               if (pwm_raw) begin
                  estado      <= MUERTO_A_ALTA;
                  Salida_Baja <= 1'b0;
               end
            end
            default: begin
               estado      <= REPOSO;
               Salida_Alta <= 1'b0;
               Salida_Baja <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_conmutador_pwm.sv
// Bench for conmutador_pwm: directed period measurements plus random
// enable/duty traffic compared each cycle against a behavioural model.
module tb_conmutador_pwm;

   localparam int T = 8;
   localparam int IDLE = 0, DEAD = 1, HI = 2, LO = 3;

   logic       Clk = 1'b0;
   logic       Reset = 1'b1;
   logic       Enable = 1'b0;
   logic [9:0] Conteo = '0;
   logic [9:0] Ciclo_Trabajo = '0;
   logic       Salida_Alta;
   logic       Salida_Baja;
   logic       Fin_Periodo;

   int checks = 0;
   int failures = 0;

   logic [9:0] cnt = '0;
   int  m_duty = 0;
   bit  m_raw = 0;
   bit  m_fin = 0;
   int  m_mode = IDLE;
   int  m_dead = 0;

   conmutador_pwm #(.TIEMPO_MUERTO(T)) dut (
      .Clk           (Clk),
      .Reset         (Reset),
      .Enable        (Enable),
      .Conteo        (Conteo),
      .Ciclo_Trabajo (Ciclo_Trabajo),
      .Salida_Alta   (Salida_Alta),
      .Salida_Baja   (Salida_Baja),
      .Fin_Periodo   (Fin_Periodo)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_duty = 0;
      m_raw  = 0;
      m_fin  = 0;
      m_mode = IDLE;
      m_dead = 0;
   endtask

   // Half-bridge behaviour: raw = count below period duty, delayed one
   // cycle; side changes always pass through T idle cycles.
   task automatic model_edge(input bit e, input logic [9:0] c,
                             input logic [9:0] d);
      bit prev;
      prev  = m_raw;
      m_fin = e && (c == 10'h3FF);
      m_raw = e && (int'(c) < m_duty);
      if (m_fin) m_duty = int'(d);
      if (!e) begin
         m_mode = IDLE;
      end else if (m_mode == IDLE) begin
         m_mode = DEAD;
         m_dead = T;
      end else if (m_mode == DEAD) begin
         m_dead--;
         if (m_dead == 0) m_mode = prev ? HI : LO;
      end else if ((m_mode == HI && !prev) || (m_mode == LO && prev)) begin
         m_mode = DEAD;
         m_dead = T;
      end
   endtask

   task automatic step(input bit e, input logic [9:0] d);
      Enable = e;
      Ciclo_Trabajo = d;
      Conteo = cnt;
      @(posedge Clk);
      model_edge(e, cnt, d);
      if (e) cnt = cnt + 10'd1;
      #1;
      chk("alta", Salida_Alta, m_mode == HI);
      chk("baja", Salida_Baja, m_mode == LO);
      chk("fin", Fin_Periodo, m_fin);
      chk("excl", Salida_Alta & Salida_Baja, 0);
   endtask

   task automatic run_period(input logic [9:0] d0, input logic [9:0] d1,
                             input int sw, output int na, output int nb,
                             output int nf);
      na = 0;
      nb = 0;
      nf = 0;
      for (int i = 0; i < 1024; i++) begin
         step(1'b1, (i < sw) ? d0 : d1);
         na += int'(Salida_Alta);
         nb += int'(Salida_Baja);
         nf += int'(Fin_Periodo);
      end
   endtask

   initial begin
      int na, nb, nf, n;
      bit found;
      logic [9:0] d;

      repeat (2) @(posedge Clk);
      #1;
      chk("rst_alta", Salida_Alta, 0);
      chk("rst_baja", Salida_Baja, 0);
      chk("rst_fin", Fin_Periodo, 0);
      Reset = 1'b0;
      model_reset();

      // First period runs on the reset duty of 0.
      run_period(10'd256, 10'd256, 1024, na, nb, nf);
      chk("p1_alta", na, 0);
      chk("p1_baja", nb, 1024 - T);
      chk("p1_fin", nf, 1);

      run_period(10'd256, 10'd256, 1024, na, nb, nf);
      chk("p2_alta", na, 256 - T);
      chk("p2_baja", nb, 1024 - 256 - T);
      chk("p2_fin", nf, 1);

      // Mid-period duty change must wait for the boundary.
      run_period(10'd256, 10'd768, 100, na, nb, nf);
      chk("p3_alta", na, 256 - T);
      chk("p3_baja", nb, 1024 - 256 - T);

      run_period(10'd4, 10'd4, 1024, na, nb, nf);
      chk("p4_alta", na, 768 - T);
      chk("p4_baja", nb, 1024 - 768 - T);

      // Pulse shorter than dead time: low side only dips.
      run_period(10'd0, 10'd0, 1024, na, nb, nf);
      chk("p5_alta", na, 0);
      chk("p5_baja", nb, 1024 - T);

      run_period(10'd0, 10'd0, 1024, na, nb, nf);
      chk("p6_alta", na, 0);
      chk("p6_baja", nb, 1024);
      chk("p6_fin", nf, 1);

      // Enable dropped mid-low, then dead time on re-enable.
      repeat (300) step(1'b1, 10'd0);
      for (int i = 0; i < 20; i++) begin
         step(1'b0, 10'd0);
         chk("dis_cnt_hold", Conteo, 10'd300);
      end
      n = 0;
      found = 0;
      for (int i = 0; i < 50 && !found; i++) begin
         step(1'b1, 10'd0);
         if (Salida_Baja || Salida_Alta) found = 1;
         else n++;
      end
      chk("reen_found", found, 1);
      chk("reen_dead", n, T);

      // Asynchronous reset while high side is on.
      found = 0;
      for (int i = 0; i < 3000 && !found; i++) begin
         step(1'b1, 10'd512);
         if (Salida_Alta) found = 1;
      end
      chk("alta_found", found, 1);
      #1 Reset = 1'b1;
      #2;
      chk("async_alta", Salida_Alta, 0);
      chk("async_baja", Salida_Baja, 0);
      Enable = 1'b0;
      repeat (2) @(posedge Clk);
      model_reset();
      #1 Reset = 1'b0;
      n = 0;
      found = 0;
      for (int i = 0; i < 50 && !found; i++) begin
         step(1'b1, 10'd512);
         if (Salida_Baja || Salida_Alta) found = 1;
         else n++;
      end
      chk("post_rst_found", found, 1);
      chk("post_rst_dead", n, T);

      // Random enable gaps and duty values, including near-boundary ones.
      for (int i = 0; i < 5000; i++) begin
         case ($urandom_range(0, 3))
            0: d = 10'($urandom_range(0, 12));
            1: d = 10'($urandom_range(1010, 1023));
            default: d = 10'($urandom_range(0, 1023));
         endcase
         step($urandom_range(0, 31) != 0, d);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/conmutador_pwm.md
CONMUTADOR_PWM -- requirements
Module: conmutador_pwm

Interface
REQ-001 Parameter: TIEMPO_MUERTO, default 8, dead-time length in Clk cycles; legal range 1..63.
REQ-002 Clk  input  1  single clock; all state updates on rising edge.
REQ-003 Reset  input  1  asynchronous, active-high reset.
REQ-004 Enable  input  1  run enable; same enable that drives the team's 10-bit up-counter feeding Conteo.
REQ-005 Conteo  input  10  switching-frequency count from that counter; advances by 1 per enabled Clk edge, wraps 10'h3FF -> 0.
REQ-006 Ciclo_Trabajo  input  10  requested duty value, in counts per 1024-count period.
REQ-007 Salida_Alta  output  1  high-side switch command, registered.
REQ-008 Salida_Baja  output  1  low-side switch command, registered.
REQ-009 Fin_Periodo  output  1  one-cycle pulse marking the period boundary, registered.

Function
REQ-010 Shadow duty register duty_act SHALL load Ciclo_Trabajo only on an edge with Enable=1 and Conteo=10'h3FF; otherwise it holds.
REQ-011 Raw compare pwm_raw SHALL register (Conteo < duty_act) on every edge with Enable=1, and SHALL register 0 when Enable=0. Latency is 1 Clk.
REQ-012 Duty boundaries: duty_act=0 gives pwm_raw always 0; duty_act=1023 gives pwm_raw 0 only for Conteo=1023. No overflow arithmetic is permitted; the compare is unsigned at 10 bits.
REQ-013 The FSM SHALL have states REPOSO, MUERTO_A_ALTA, ALTA, MUERTO_A_BAJA and BAJA.
REQ-014 Output decode: Salida_Alta=1 only in ALTA; Salida_Baja=1 only in BAJA; both outputs are 0 in all other states. Outputs are driven directly from registered state, so they are glitch-free.
REQ-015 REPOSO: when Enable=1, go to MUERTO_A_ALTA if pwm_raw=1, else go to MUERTO_A_BAJA.
REQ-016 On entering any MUERTO_* state, the dead-time timer SHALL load TIEMPO_MUERTO. Each MUERTO_* state lasts exactly TIEMPO_MUERTO cycles.
REQ-017 On MUERTO_* expiry, the FSM SHALL enter ALTA if pwm_raw=1, else BAJA, regardless of the original target. This covers pulses shorter than the dead time.
REQ-018 ALTA: when pwm_raw=0, go to MUERTO_A_BAJA. BAJA: when pwm_raw=1, go to MUERTO_A_ALTA.
REQ-019 Enable=0 in any state SHALL force REPOSO on the next edge; this has priority over all other transitions.
REQ-020 Invariant: Salida_Alta and Salida_Baja SHALL never be 1 in the same cycle, including across reset and Enable transitions.
REQ-021 Fin_Periodo SHALL be 1 for exactly the one cycle following an edge with Enable=1 and Conteo=10'h3FF, and 0 otherwise.
REQ-022 Edge timing: Salida_Alta falls 2 edges after the edge sampling Conteo=duty_act. Salida_Baja rises TIEMPO_MUERTO cycles after that. The rising-side sequence is symmetric.

Reset
REQ-023 Reset=1 SHALL immediately (asynchronously) set: state=REPOSO, Salida_Alta=0, Salida_Baja=0, Fin_Periodo=0, duty_act=0, pwm_raw=0, timer=0.
REQ-024 Reset asserted mid-ALTA or mid-dead-time SHALL drop both outputs without waiting for a Clk edge.
REQ-025 After Reset release, no switch output SHALL assert before one full dead time has elapsed.

Structure
REQ-026 Shared package pwm_pkg SHALL hold: CNT_W=10, CNT_MAX=10'h3FF, the FSM state encoding, and the TIEMPO_MUERTO range limits.
REQ-027 The dead-time down-counter SHALL be the sub-module temporizador_muerto, with ports Clk, Reset, Carga, Valor[5:0], Expira.
REQ-028 Salida_Alta, Salida_Baja and Fin_Periodo SHALL be flop outputs; there is no combinational path from any input to any output.

Verification
REQ-029 TIEMPO_MUERTO=8; Ciclo_Trabajo=256 loaded at Conteo=3FF -> in the next period Salida_Alta is high 248 cycles, Salida_Baja high 760 cycles, and both are 0 for 8 cycles at each transition.
REQ-030 Ciclo_Trabajo=0 -> Salida_Alta never 1; Salida_Baja continuously 1 after the first 8-cycle dead time; Fin_Periodo pulses every 1024 enabled cycles.
REQ-031 Ciclo_Trabajo=4, TIEMPO_MUERTO=8 -> Salida_Alta stays 0; Salida_Baja drops for exactly 8 cycles per period, then returns.
REQ-032 Ciclo_Trabajo changed from 256 to 768 at Conteo=100 -> the current period is unaffected; the next period gives Salida_Alta 760 cycles high.
REQ-033 Reset pulse during ALTA -> both outputs 0 before the next Clk edge; after release, Salida_Baja asserts no earlier than 8 enabled cycles later.
REQ-034 Enable dropped for 20 cycles mid-BAJA -> both outputs 0 from the next edge; on re-enable there are 8 dead cycles before either output asserts; Conteo and duty_act are held throughout.
